// File: rtl/mt_info_queue.sv
// MT info word buffer: circular FIFO (mode=0) or sliding shift window with tap read (mode=1).
// Registered read data, registered occupancy flags, sticky error flags and a 3-bit state code.
module mt_info_queue #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 32,
    parameter int AW     = $clog2(DEPTH),
    parameter int CW     = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              mode,
    input  logic              WE,
    input  logic              RE,
    input  logic [AW-1:0]     rd_idx,
    input  logic [DATA_W-1:0] MT_info_in,
    output logic [DATA_W-1:0] MT_info_out,
    output logic              out_valid,
    output logic [CW-1:0]     count,
    output logic              full,
    output logic              empty,
    output logic              overflow,
    output logic              underflow,
    output logic [2:0]        state_check
);

    localparam logic [2:0] ST_EMPTY   = 3'd0;
    localparam logic [2:0] ST_FILLING = 3'd1;
    localparam logic [2:0] ST_FULL    = 3'd2;
    localparam logic [2:0] ST_ERROR   = 3'd3;

    localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
    localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH - 1);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic              mode_q;

    logic              clear;
    logic              tap_ok;
    logic              wr_acc;
    logic              rd_acc;
    logic              ovf_set;
    logic              unf_set;
    logic [CW-1:0]     count_n;
    logic [2:0]        state_n;

    // A mode change behaves exactly like clr on the edge where it is seen.
    assign clear  = clr | (mode != mode_q);
    assign tap_ok = (CW'(rd_idx) < count);

    always_comb begin
        wr_acc  = 1'b0;
        rd_acc  = 1'b0;
        ovf_set = 1'b0;
        unf_set = 1'b0;
        count_n = count;
        if (clear) begin
            count_n = '0;
        end else if (!mode_q) begin
            rd_acc  = RE & ~empty;
            wr_acc  = WE & (~full | rd_acc);
            ovf_set = WE & ~wr_acc;
            unf_set = RE & ~rd_acc;
            count_n = count + CW'(wr_acc) - CW'(rd_acc);
        end else begin
            rd_acc  = RE & tap_ok;
            unf_set = RE & ~tap_ok;
            wr_acc  = WE;
            if (WE && (count != DEPTH_C))
                count_n = count + CW'(1);
        end
    end

    always_comb begin
        state_n = ST_FILLING;
        if (clear)
            state_n = ST_EMPTY;
        else if ((state_check == ST_ERROR) || ovf_set || unf_set)
            state_n = ST_ERROR;
        else if (count_n == '0)
            state_n = ST_EMPTY;
        else if (count_n == DEPTH_C)
            state_n = ST_FULL;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++)
                mem[i] <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            mode_q      <= 1'b0;
            count       <= '0;
            full        <= 1'b0;
            empty       <= 1'b1;
            MT_info_out <= '0;
            out_valid   <= 1'b0;
            overflow    <= 1'b0;
            underflow   <= 1'b0;
            state_check <= ST_EMPTY;
        end else begin
            mode_q      <= mode;
            count       <= count_n;
            full        <= (count_n == DEPTH_C);
            empty       <= (count_n == '0);
            state_check <= state_n;
            if (clear) begin
                wr_ptr    <= '0;
                rd_ptr    <= '0;
                out_valid <= 1'b0;
                overflow  <= 1'b0;
                underflow <= 1'b0;
            end else begin
                out_valid <= rd_acc;
                if (ovf_set)
                    overflow <= 1'b1;
                if (unf_set)
                    underflow <= 1'b1;
                if (!mode_q) begin
                    // On a full WE&RE the pointers coincide; the read still sees the old word.
                    if (wr_acc) begin
                        mem[wr_ptr] <= MT_info_in;
                        wr_ptr      <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + AW'(1);
                    end
                    if (rd_acc) begin
                        MT_info_out <= mem[rd_ptr];
                        rd_ptr      <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + AW'(1);
                    end
                end else begin
                    if (RE)
                        MT_info_out <= tap_ok ? mem[rd_idx] : '0;
                    if (WE) begin
                        mem[0] <= MT_info_in;
                        for (int unsigned i = 1; i < DEPTH; i++)
                            mem[i] <= mem[i-1];
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_mt_info_queue.sv
// Bench for mt_info_queue (DEPTH=4): directed scenarios plus random traffic, all outputs
// compared each cycle against a queue-based reference model.
module tb_mt_info_queue;

    localparam int DW = 32;
    localparam int D  = 4;
    localparam int AW = $clog2(D);
    localparam int CW = $clog2(D + 1);

    logic          clk;
    logic          rst_n;
    logic          clr;
    logic          mode;
    logic          WE;
    logic          RE;
    logic [AW-1:0] rd_idx;
    logic [DW-1:0] MT_info_in;
    logic [DW-1:0] MT_info_out;
    logic          out_valid;
    logic [CW-1:0] count;
    logic          full;
    logic          empty;
    logic          overflow;
    logic          underflow;
    logic [2:0]    state_check;

    mt_info_queue #(.DATA_W(DW), .DEPTH(D)) dut (
        .clk(clk), .rst_n(rst_n), .clr(clr), .mode(mode), .WE(WE), .RE(RE),
        .rd_idx(rd_idx), .MT_info_in(MT_info_in), .MT_info_out(MT_info_out),
        .out_valid(out_valid), .count(count), .full(full), .empty(empty),
        .overflow(overflow), .underflow(underflow), .state_check(state_check)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: q[0] is the FIFO head in mode 0 and the newest entry in mode 1.
    logic [DW-1:0] q[$];
    logic [DW-1:0] m_out;
    logic          m_valid, m_ovf, m_unf, m_err, m_mode;
    logic          drv_mode;

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_out = '0; m_valid = 0; m_ovf = 0; m_unf = 0; m_err = 0; m_mode = 0;
    endtask

    task automatic model_step(input logic we, re, input int idx, input logic [DW-1:0] din,
                              input logic c, input logic md);
        if (c || md != m_mode) begin
            q.delete();
            m_valid = 0; m_ovf = 0; m_unf = 0; m_err = 0; m_mode = md;
        end else if (!md) begin
            logic rd_ok;
            rd_ok   = re && q.size() > 0;
            m_valid = rd_ok;
            if (rd_ok) m_out = q.pop_front();
            else if (re) begin m_unf = 1; m_err = 1; end
            if (we) begin
                if (q.size() < D) q.push_back(din);
                else begin m_ovf = 1; m_err = 1; end
            end
        end else begin
            m_valid = 0;
            if (re) begin
                if (idx < q.size()) begin m_out = q[idx]; m_valid = 1; end
                else begin m_out = '0; m_unf = 1; m_err = 1; end
            end
            if (we) begin
                q.push_front(din);
                if (q.size() > D) void'(q.pop_back());
            end
        end
    endtask

    task automatic compare_all();
        int sz;
        logic [2:0] st;
        sz = q.size();
        st = m_err ? 3'd3 : (sz == 0) ? 3'd0 : (sz == D) ? 3'd2 : 3'd1;
        check("out",       MT_info_out, m_out);
        check("out_valid", DW'(out_valid), DW'(m_valid));
        check("count",     DW'(count), DW'(sz));
        check("full",      DW'(full), DW'(sz == D));
        check("empty",     DW'(empty), DW'(sz == 0));
        check("overflow",  DW'(overflow), DW'(m_ovf));
        check("underflow", DW'(underflow), DW'(m_unf));
        check("state",     DW'(state_check), DW'(st));
    endtask

    task automatic cyc(input logic we, re, input logic [AW-1:0] idx, input logic [DW-1:0] din,
                       input logic c);
        WE = we; RE = re; rd_idx = idx; MT_info_in = din; clr = c; mode = drv_mode;
        @(posedge clk);
        model_step(we, re, int'(idx), din, c, drv_mode);
        @(negedge clk);
        compare_all();
    endtask

    task automatic idle_inputs();
        WE = 0; RE = 0; rd_idx = '0; MT_info_in = '0; clr = 0; mode = drv_mode;
    endtask

    initial begin
        drv_mode = 0;
        rst_n = 0;
        idle_inputs();
        model_reset();
        #22 rst_n = 1;
        @(negedge clk);
        compare_all();

        // T1: asynchronous reset in the middle of activity
        for (int i = 0; i < 5; i++) cyc(1, 0, '0, 32'h100 + i, 0);
        idle_inputs();
        #2 rst_n = 0;
        #1;
        model_reset();
        compare_all();
        check("t1_state", DW'(state_check), 0);
        #1 rst_n = 1;
        cyc(0, 0, '0, '0, 0);

        // T2: fill, overflow, drain
        for (int i = 1; i <= 4; i++) cyc(1, 0, '0, 32'hA0 + i, 0);
        check("t2_full", DW'(full), 1);
        check("t2_state_full", DW'(state_check), 2);
        cyc(1, 0, '0, 32'hA5, 0);
        check("t2_ovf", DW'(overflow), 1);
        check("t2_state_err", DW'(state_check), 3);
        for (int i = 1; i <= 4; i++) begin
            cyc(0, 1, '0, '0, 0);
            check("t2_drain", MT_info_out, 32'hA0 + i);
        end
        check("t2_empty", DW'(empty), 1);

        // T3: wrap and simultaneous access when full
        cyc(0, 0, '0, '0, 1);
        for (int i = 1; i <= 3; i++) cyc(1, 0, '0, 32'hB0 + i, 0);
        cyc(0, 1, '0, '0, 0);
        cyc(0, 1, '0, '0, 0);
        for (int i = 4; i <= 6; i++) cyc(1, 0, '0, 32'hB0 + i, 0);
        check("t3_full", DW'(full), 1);
        cyc(1, 1, '0, 32'hB7, 0);
        check("t3_simul_out", MT_info_out, 32'hB3);
        check("t3_simul_count", DW'(count), 4);
        cyc(0, 0, '0, '0, 1);
        for (int i = 0; i < 8; i++) begin
            cyc(1, 0, '0, 32'hC0 + i, 0);
            cyc(0, 1, '0, '0, 0);
            check("t3_stream", MT_info_out, 32'hC0 + i);
        end

        // T4: WE&RE on empty
        cyc(0, 0, '0, '0, 1);
        cyc(1, 1, '0, 32'h55, 0);
        check("t4_count", DW'(count), 1);
        check("t4_unf", DW'(underflow), 1);
        check("t4_valid", DW'(out_valid), 0);
        cyc(0, 1, '0, '0, 0);
        check("t4_read", MT_info_out, 32'h55);

        // T5: shift window
        drv_mode = 1;
        cyc(0, 0, '0, '0, 0);
        for (int i = 1; i <= 6; i++) cyc(1, 0, '0, i, 0);
        check("t5_count", DW'(count), 4);
        for (int i = 0; i < 4; i++) begin
            cyc(0, 1, AW'(i), '0, 0);
            check("t5_tap", MT_info_out, 6 - i);
        end
        cyc(0, 0, '0, '0, 1);
        cyc(1, 0, '0, 32'h11, 0);
        cyc(1, 0, '0, 32'h22, 0);
        cyc(0, 1, AW'(3), '0, 0);
        check("t5_bad_tap_out", MT_info_out, 0);
        check("t5_bad_tap_unf", DW'(underflow), 1);
        check("t5_bad_tap_valid", DW'(out_valid), 0);

        // T6: mode toggle clears, clr beats WE
        cyc(0, 0, '0, '0, 1);
        for (int i = 0; i < 3; i++) cyc(1, 0, '0, 32'hD0 + i, 0);
        drv_mode = 0;
        cyc(0, 0, '0, '0, 0);
        check("t6_count", DW'(count), 0);
        check("t6_state", DW'(state_check), 0);
        cyc(1, 0, '0, 32'hE1, 0);
        cyc(1, 0, '0, 32'hE2, 1);
        check("t6_clr_wins", DW'(count), 0);

        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 199) == 0) drv_mode = ~drv_mode;
            cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), AW'($urandom_range(0, D - 1)),
                $urandom, ($urandom_range(0, 49) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
